// File: rtl/lcd_write_engine_if.sv
// Command handshake between the LCD sequencers (master) and lcd_write_engine (slave).
// A write transfers on a rising edge where cmd_valid && cmd_ready; cmd_rs/cmd_data are sampled only then.
interface lcd_write_engine_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rs;
   logic [7:0] cmd_data;
   logic       done;
   logic       busy;

   modport master (
      output cmd_valid, cmd_rs, cmd_data,
      input  cmd_ready, done, busy
   );

   modport slave (
      input  cmd_valid, cmd_rs, cmd_data,
      output cmd_ready, done, busy
   );
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780 bus write stage: registered E strobe with setup/pulse/hold and execute hold-off.
// Optional 4-entry command FIFO in front of the FSM when LCD_CMD_FIFO_EN is defined.
module lcd_write_engine #(
   parameter int POWERUP_CYC   = 15000,
   parameter int SETUP_CYC     = 1,
   parameter int PULSE_CYC     = 1,
   parameter int HOLD_CYC      = 1,
   parameter int EXEC_CYC      = 40,
   parameter int LONG_EXEC_CYC = 1640,
   parameter int CNT_W         = 14
) (
   input  logic                clk,
   input  logic                rst,
   lcd_write_engine_if.slave   cmd,
   output logic                LCD_E,
   output logic                LCD_RS,
   output logic                LCD_RW,
   output logic [7:0]          LCD_DATA,
   output logic [2:0]          dbg_state_o
);

   typedef enum logic [2:0] {
      S_PWRUP = 3'd0,
      S_IDLE  = 3'd1,
      S_SETUP = 3'd2,
      S_PULSE = 3'd3,
      S_HOLD  = 3'd4,
      S_EXEC  = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] TC_PWR   = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] TC_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] TC_PULSE = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TC_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] TC_EXEC  = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] TC_LONG  = CNT_W'(LONG_EXEC_CYC - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tc;
   logic             e_q, e_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             long_q, long_d;
   logic             done_q, done_d;
   logic             last;

   // Source of the next write and the condition that starts it from IDLE.
   logic             start;
   logic             src_rs;
   logic [7:0]       src_data;
   logic             src_long;

`ifdef LCD_CMD_FIFO_EN
   logic [8:0] fifo_q [4];
   logic [1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0] count_q;
   logic       fifo_full, fifo_empty, push, pop;

   assign fifo_full  = (count_q == 3'd4);
   assign fifo_empty = (count_q == 3'd0);
   assign push       = cmd.cmd_valid && !fifo_full;
   assign pop        = (state_q == S_IDLE) && !fifo_empty;

   assign start      = pop;
   assign src_rs     = fifo_q[rd_ptr_q][8];
   assign src_data   = fifo_q[rd_ptr_q][7:0];
   assign cmd.cmd_ready = !fifo_full;
   assign cmd.busy   = (state_q != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
         count_q <= count_q + 3'(push) - 3'(pop);
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= {cmd.cmd_rs, cmd.cmd_data};
   end
`else
   assign start      = cmd.cmd_valid && (state_q == S_IDLE);
   assign src_rs     = cmd.cmd_rs;
   assign src_data   = cmd.cmd_data;
   assign cmd.cmd_ready = (state_q == S_IDLE);
   assign cmd.busy   = (state_q != S_IDLE);
`endif

   // Clear display (01) and return home (02/03) need the long execute time.
   assign src_long = !src_rs && (src_data[7:2] == 6'd0) && (src_data[1:0] != 2'd0);

   always_comb begin
      tc = '0;
      unique case (state_q)
         S_PWRUP: tc = TC_PWR;
         S_SETUP: tc = TC_SETUP;
         S_PULSE: tc = TC_PULSE;
         S_HOLD:  tc = TC_HOLD;
         S_EXEC:  tc = long_q ? TC_LONG : TC_EXEC;
         default: tc = '0;
      endcase
   end

   assign last = (cnt_q == tc);

   always_comb begin
      state_d = state_q;
      rs_d    = rs_q;
      data_d  = data_q;
      long_d  = long_q;
      unique case (state_q)
         S_PWRUP: if (last) state_d = S_IDLE;
         S_IDLE: begin
            if (start) begin
               rs_d    = src_rs;
               data_d  = src_data;
               long_d  = src_long;
               state_d = S_SETUP;
            end
         end
         S_SETUP: if (last) state_d = S_PULSE;
         S_PULSE: if (last) state_d = S_HOLD;
         S_HOLD:  if (last) state_d = S_EXEC;
         S_EXEC:  if (last) state_d = S_IDLE;
         default: state_d = S_PWRUP;
      endcase
      cnt_d  = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 1'b1;
      e_d    = (state_d == S_PULSE);
      done_d = (state_q == S_EXEC) && (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_PWRUP;
         cnt_q   <= '0;
         e_q     <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         long_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         long_q  <= long_d;
         done_q  <= done_d;
      end
   end

   assign LCD_E       = e_q;
   assign LCD_RS      = rs_q;
   assign LCD_RW      = 1'b0;
   assign LCD_DATA    = data_q;
   assign cmd.done    = done_q;
   assign dbg_state_o = state_q;

endmodule
